qsin_phase_gen: RTL and testbench
=================================

# qsin_phase_gen

Phase-accumulator front end for the quarter-wave sine path. Each enabled cycle it advances a programmable phase accumulator, splits the phase into a quadrant and a mirrored quarter-wave LUT address, and drives that address to the quarter-sine ROM. It delays the quadrant and a valid flag by the ROM read latency, so both arrive aligned with the ROM data. The aligned quadrant/sample pair feeds the downstream quadrant-to-sine sign-restore stage.

## Interface
- `PHASE_W`, default 32: phase accumulator and frequency word width; must satisfy `PHASE_W >= ADDR_W + 2`.
- `ADDR_W`, default 10: quarter-wave LUT address width (depth 2^ADDR_W).
- `ROM_LAT`, default 1: ROM read latency in cycles, from address register to data; range 1..4.
- `clk` in 1: sole clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: sample strobe; when high, emits one sample and advances the phase.
- `freq_word` in PHASE_W: phase increment per sample, unsigned.
- `freq_load` in 1: when high, captures `freq_word` into the increment register.
- `phase_clr` in 1: zeroes the accumulator.
- `rom_addr` out ADDR_W: registered quarter-wave ROM address.
- `quadrant` out 2: quadrant aligned with the ROM data output.
- `sample_valid` out 1: high for one cycle per emitted sample, aligned with the ROM data.

## Operation
- State:
  - `phase` (PHASE_W)
  - `inc` (PHASE_W)
  - `addr` register
  - quadrant/valid shift pipeline of depth ROM_LAT+1
- Address decode from the phase used this cycle (`p`):
  - `q = p[PHASE_W-1:PHASE_W-2]`
  - `idx = p[PHASE_W-3 -: ADDR_W]`
  - `rom_addr <= q[0] ? ~idx : idx` (quadrants 1 and 3 mirrored)
- Step cycle (`en`=1, `phase_clr`=0):
  - register `rom_addr` from `phase`
  - push `{1'b1, q}` into the pipeline
  - `phase <= phase + inc`, modulo 2^PHASE_W (natural wrap, no saturation)
- Idle cycle (`en`=0): `phase` and `rom_addr` hold; push `{1'b0, 2'b00}` into the pipeline.
- `phase_clr`=1:
  - `phase <= 0`
  - it has priority over `en`: no sample is emitted and a `{0, 00}` entry is pushed
- `freq_load`=1: `inc <= freq_word`.
  - With `en` in the same cycle, that step uses the old `inc`.
  - The new value applies from the next step.
- `freq_load` and `phase_clr` in the same cycle: both take effect.
- Reset:
  - `phase`, `inc`, `rom_addr`, the pipeline, `quadrant` and `sample_valid` all go to 0
  - in-flight samples are discarded
  - `reset` overrides all other inputs

## Timing
- `en` at edge t (phase P) → `rom_addr(P)` valid after edge t+1.
- ROM data is valid after edge t+1+ROM_LAT.
- `quadrant(P)` and `sample_valid`=1 are valid after edge t+1+ROM_LAT: latency ROM_LAT+1 cycles (2 at default).
- Throughput: one sample per cycle with `en` held high; the `sample_valid` pattern is `en` delayed by ROM_LAT+1.
- No back-pressure: the consumer must accept every valid sample.
- Reset values of all outputs: 0, starting the cycle after `reset` is sampled high.

## Configuration
- `QSIN_DITHER_EN` defined:
  - Adds a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1.
  - Reset loads the seed; the LFSR advances only on step cycles.
  - Address decode uses `p = phase + lfsr[D-1:0]` (zero-extended, mod 2^PHASE_W), with D = min(16, PHASE_W-ADDR_W-2).
  - The accumulator itself is undithered.
- `QSIN_DITHER_EN` undefined: no LFSR; `p = phase`.

## Test plan
Defaults throughout: PHASE_W=32, ADDR_W=10, ROM_LAT=1.
- Reset: drive random inputs, hold `reset` 3 cycles → `rom_addr`=0, `quadrant`=0, `sample_valid`=0; after release with `en`=0, all outputs stay 0.
- Linear sweep: load `freq_word`=32'h0010_0000, `en` held high for 4096 cycles →
  - `rom_addr` runs 0,1,…,1023 (quadrant 0), then 1023…0 (quadrant 1), then repeats for quadrants 2 and 3
  - `quadrant` lags `rom_addr` by 1 cycle
  - `sample_valid` first rises 2 cycles after `en`
- Quadrant wrap: load `freq_word`=32'h4000_0000, `en` high → `rom_addr` 0,1023,0,1023,0; `quadrant` 0,1,2,3,0; accumulator wraps cleanly.
- Gapped enable: `en` pattern 1,0,1,1,0,1 → `sample_valid` shows the same pattern shifted 2 cycles; phase advances only on the 4 step cycles.
- Simultaneous events (macro undefined):
  - `inc`=32'h0010_0000; `freq_load` with `freq_word`=32'h0020_0000 and `en` in the same cycle → that step advances by 1 address, later steps by 2.
  - `phase_clr`+`en` → no valid emitted; the next step emits `rom_addr`=0, `quadrant`=0.
- Dither, macro defined: `freq_word`=32'h0010_0000, 16 steps → `rom_addr` matches a golden model using the LFSR from seed ACE1; the same run without the macro matches the linear sweep exactly.

Source files
------------

// File: rtl/qsin_phase_gen.sv
// qsin_phase_gen: phase accumulator and quarter-wave ROM address front end with quadrant/valid
// alignment to the ROM read latency. Define QSIN_DITHER_EN to add LFSR dither to the decode.
module qsin_phase_gen #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic               freq_load,
    input  logic               phase_clr,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic [1:0]         quadrant,
    output logic               sample_valid
);

    localparam int unsigned PipeDepth = ROM_LAT + 1;
    localparam int unsigned FracW     = PHASE_W - ADDR_W - 2;

    logic [PHASE_W-1:0]        phase_q;
    logic [PHASE_W-1:0]        inc_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [PipeDepth-1:0]      valid_pipe_q;
    logic [PipeDepth-1:0][1:0] quad_pipe_q;

    logic [PHASE_W-1:0] dec_phase;
    logic [1:0]         dec_quad;
    logic [ADDR_W-1:0]  dec_idx;
    logic [ADDR_W-1:0]  addr_d;
    logic               step;

    // phase_clr wins over en: a cleared cycle never emits a sample
    assign step = en & ~phase_clr;

`ifdef QSIN_DITHER_EN
    localparam int unsigned DitherW  = (FracW < 16) ? FracW : 16;
    localparam logic [15:0] LfsrSeed = 16'hACE1;
    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LfsrTaps = 16'hB400;

    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LfsrSeed;
        end else if (step) begin
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
        end
    end

    if (DitherW > 0) begin : g_dither
        assign dec_phase = phase_q + PHASE_W'(lfsr_q[DitherW-1:0]);
        if (DitherW < 16) begin : g_lfsr_unused
            logic unused_lfsr_bits;
            assign unused_lfsr_bits = ^lfsr_q[15:DitherW];
        end
    end else begin : g_no_dither
        logic unused_lfsr;
        assign unused_lfsr = ^lfsr_q;
        assign dec_phase   = phase_q;
    end
`else
    assign dec_phase = phase_q;
`endif

    // Quadrants 1 and 3 walk the quarter wave backwards
    assign dec_quad = dec_phase[PHASE_W-1 -: 2];
    assign dec_idx  = dec_phase[PHASE_W-3 -: ADDR_W];
    assign addr_d   = dec_quad[0] ? ~dec_idx : dec_idx;

    if (FracW > 0) begin : g_frac_unused
        logic unused_frac_bits;
        assign unused_frac_bits = ^dec_phase[FracW-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
            inc_q   <= '0;
            addr_q  <= '0;
        end else begin
            if (phase_clr) begin
                phase_q <= '0;
            end else if (en) begin
                phase_q <= phase_q + inc_q;
            end
            if (step) begin
                addr_q <= addr_d;
            end
            if (freq_load) begin
                inc_q <= freq_word;
            end
        end
    end

    // Stage 0 lines up with addr_q; stage ROM_LAT lines up with the ROM data
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_pipe_q <= '0;
            quad_pipe_q  <= '0;
        end else begin
            valid_pipe_q <= {valid_pipe_q[PipeDepth-2:0], step};
            quad_pipe_q  <= {quad_pipe_q[PipeDepth-2:0], (step ? dec_quad : 2'b00)};
        end
    end

    assign rom_addr     = addr_q;
    assign quadrant     = quad_pipe_q[ROM_LAT];
    assign sample_valid = valid_pipe_q[ROM_LAT];

endmodule

// File: tb/tb_qsin_phase_gen.sv
// tb_qsin_phase_gen: directed and randomized checks of qsin_phase_gen against a cycle-level
// arithmetic model of the phase generator (honours QSIN_DITHER_EN).
module tb_qsin_phase_gen;

    localparam int unsigned PhaseW = 32;
    localparam int unsigned AddrW  = 10;
    localparam int unsigned RomLat = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              en = 1'b0;
    logic [PhaseW-1:0] freq_word = '0;
    logic              freq_load = 1'b0;
    logic              phase_clr = 1'b0;
    logic [AddrW-1:0]  rom_addr;
    logic [1:0]        quadrant;
    logic              sample_valid;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [31:0] m_phase;
    logic [31:0] m_inc;
    int unsigned m_addr;
    logic [15:0] m_lfsr;
    int unsigned hist_valid [RomLat+1];
    int unsigned hist_quad [RomLat+1];

    qsin_phase_gen #(
        .PHASE_W (PhaseW),
        .ADDR_W  (AddrW),
        .ROM_LAT (RomLat)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .freq_word    (freq_word),
        .freq_load    (freq_load),
        .phase_clr    (phase_clr),
        .rom_addr     (rom_addr),
        .quadrant     (quadrant),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    // One clock edge worth of model behaviour, from the sampled inputs
    task automatic model_edge(input logic r, input logic e, input logic fl, input logic pc,
                              input logic [31:0] fw);
        logic [31:0] p;
        int unsigned q;
        int unsigned idx;
        int unsigned push_v;
        int unsigned push_q;
        if (r) begin
            m_phase = 0;
            m_inc   = 0;
            m_addr  = 0;
            m_lfsr  = 16'hACE1;
            for (int i = 0; i <= RomLat; i++) begin
                hist_valid[i] = 0;
                hist_quad[i]  = 0;
            end
            return;
        end
        push_v = 0;
        push_q = 0;
        if (pc) begin
            m_phase = 0;
        end else if (e) begin
            p = m_phase;
`ifdef QSIN_DITHER_EN
            p = m_phase + {16'h0000, m_lfsr};
            if (m_lfsr % 2 == 1) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
            else                 m_lfsr = m_lfsr >> 1;
`endif
            q   = int'(p >> 30);
            idx = int'((p >> 20) % 1024);
            m_addr = (q % 2 == 1) ? (1023 - idx) : idx;
            push_v = 1;
            push_q = q;
            m_phase = m_phase + m_inc;
        end
        if (fl) m_inc = fw;
        for (int i = RomLat; i > 0; i--) begin
            hist_valid[i] = hist_valid[i-1];
            hist_quad[i]  = hist_quad[i-1];
        end
        hist_valid[0] = push_v;
        hist_quad[0]  = push_q;
    endtask

    // Drive at negedge, clock once, compare all outputs at the following negedge
    task automatic step(input logic r, input logic e, input logic fl, input logic pc,
                        input logic [31:0] fw);
        reset     = r;
        en        = e;
        freq_load = fl;
        phase_clr = pc;
        freq_word = fw;
        @(posedge clk);
        model_edge(r, e, fl, pc, fw);
        @(negedge clk);
        check("rom_addr", 32'(rom_addr), m_addr);
        check("quadrant", 32'(quadrant), hist_quad[RomLat]);
        check("sample_valid", 32'(sample_valid), hist_valid[RomLat]);
    endtask

    initial begin
        int unsigned wrap_addr [5];
        int unsigned gap_pat [6];
        wrap_addr = '{0, 1023, 0, 1023, 0};
        gap_pat   = '{1, 0, 1, 1, 0, 1};
        @(negedge clk);

        // Reset overrides random activity on every other input
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'($urandom), 1'($urandom), $urandom);
            check("reset_addr_zero", 32'(rom_addr), 0);
            check("reset_valid_zero", 32'(sample_valid), 0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, $urandom);
        check("idle_after_reset_addr", 32'(rom_addr), 0);

        // Linear sweep over all four quadrants
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0010_0000);
        for (int i = 0; i < 4096; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Quadrant wrap with a quarter-turn increment
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h4000_0000);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            check("wrap_addr", 32'(rom_addr), wrap_addr[i]);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Gapped enable
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0010_0000);
        for (int i = 0; i < 6; i++) step(1'b0, 1'(gap_pat[i]), 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("gap_final_addr", 32'(rom_addr), 3);

        // Load coinciding with a step: old increment for that step, new one afterwards
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0010_0000);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0020_0000);
        check("load_step0_addr", 32'(rom_addr), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("load_step1_addr", 32'(rom_addr), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("load_step2_addr", 32'(rom_addr), 3);

        // Clear with enable emits nothing; next step restarts at address 0
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("clr_restart_addr", 32'(rom_addr), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("clr_restart_valid", 32'(sample_valid), 1);
        check("clr_restart_quad", 32'(quadrant), 0);

        // Randomized traffic including rare resets and coincident events
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 1) == 1) ? $urandom : ($urandom >> 8));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
